// File: rtl/grid2048_engine.sv
// 2048 game engine: NxN grid of exponent tiles, random spawn, slide/merge moves, score/win/game-over tracking.
// Latency: a move takes N cycles (one line per cycle); a spawn scans one cell per cycle; CHECK takes 1 cycle.
// Backpressure: key_ready only in WAIT with no load pending; keys offered at any other time are dropped, not queued.
// Ports: clk/rst (async active-low); new_game restart; key_valid/key_dir/key_ready move input;
//        rand_in random source; ld_en/ld_addr/ld_exp cell load; rd_addr/rd_exp registered display read;
//        score, busy, game_over, win, move_done status.
module grid2048_engine #(
  parameter int N       = 4,
  parameter int EXP_W   = 4,
  parameter int WIN_EXP = 11,
  parameter int SCORE_W = 20,
  parameter int RAND_W  = 16,
  parameter int IDX_W   = $clog2(N * N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               new_game,
  input  logic               key_valid,
  input  logic [1:0]         key_dir,
  output logic               key_ready,
  input  logic [RAND_W-1:0]  rand_in,
  input  logic               ld_en,
  input  logic [IDX_W-1:0]   ld_addr,
  input  logic [EXP_W-1:0]   ld_exp,
  input  logic [IDX_W-1:0]   rd_addr,
  output logic [EXP_W-1:0]   rd_exp,
  output logic [SCORE_W-1:0] score,
  output logic               busy,
  output logic               game_over,
  output logic               win,
  output logic               move_done
);

  localparam int NC = N * N;
  // Wide enough for score plus up to N/2 merge gains of one line without wrapping.
  localparam int GW = SCORE_W + 3;
  localparam logic [EXP_W-1:0]   EXP_MAX   = '1;
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  typedef enum logic [2:0] {INIT, SPAWN, WAIT, MOVE, CHECK, OVER} state_t;
  state_t state, state_nx;

  logic [EXP_W-1:0] cells [NC];
  logic [IDX_W-1:0] spawn_idx;
  logic [IDX_W-1:0] scan_cnt;
  logic [1:0]       spawn_left;
  logic [IDX_W-1:0] line_cnt;
  logic [1:0]       move_dir;
  logic             moved;
  logic             key_pend;

  logic             spawn_hit, scan_last, line_last, board_stuck;
  logic [IDX_W-1:0] spawn_start, spawn_next;
  logic [EXP_W-1:0] spawn_val;
  logic [EXP_W-1:0] line_in  [N];
  logic [EXP_W-1:0] line_out [N];
  logic [GW-1:0]    line_gain, score_sum;
  logic             line_sat, line_win, line_chg;
  logic [SCORE_W-1:0] score_nx;

  // Only the low index bits and the top nibble of the random source matter.
  logic unused_rand;
  assign unused_rand = ^rand_in;

  // Position k along a line is counted from the destination edge outward.
  function automatic logic [IDX_W-1:0] cell_at(input logic [1:0] dir, input logic [IDX_W-1:0] line, input int k);
    int l, r, c;
    l = int'(line);
    case (dir)
      2'd0:    begin r = l;         c = N - 1 - k; end
      2'd1:    begin r = l;         c = k;         end
      2'd2:    begin r = k;         c = l;         end
      default: begin r = N - 1 - k; c = l;         end
    endcase
    return IDX_W'(r * N + c);
  endfunction

  assign spawn_start = IDX_W'(int'(rand_in[IDX_W-1:0]) % NC);
  assign spawn_next  = (int'(spawn_idx) == NC - 1) ? '0 : spawn_idx + 1'b1;
  assign spawn_val   = (rand_in[RAND_W-1 -: 4] == 4'hF) ? EXP_W'(2) : EXP_W'(1);
  assign spawn_hit   = (cells[spawn_idx] == '0);
  assign scan_last   = (int'(scan_cnt) == NC - 1);
  assign line_last   = (int'(line_cnt) == N - 1);

  // One-pass slide: a pending tile either merges with the next equal tile or is
  // emitted as-is, which is equivalent to compress / merge-once / compress.
  always_comb begin
    int o;
    logic have;
    logic [EXP_W-1:0] pend;
    o = 0;
    have = 1'b0;
    pend = '0;
    line_gain = '0;
    line_sat = 1'b0;
    line_win = 1'b0;
    line_chg = 1'b0;
    for (int k = 0; k < N; k++) begin
      line_out[k] = '0;
      line_in[k]  = cells[cell_at(move_dir, line_cnt, k)];
    end
    for (int k = 0; k < N; k++) begin
      if (line_in[k] != '0) begin
        if (have && pend == line_in[k] && pend != EXP_MAX) begin
          for (int j = 0; j < N; j++) if (j == o) line_out[j] = pend + 1'b1;
          o = o + 1;
          have = 1'b0;
          if (int'(pend) + 1 >= WIN_EXP) line_win = 1'b1;
          if (int'(pend) + 1 >= SCORE_W) line_sat = 1'b1;
          else line_gain = line_gain + (GW'(1) << (pend + 1'b1));
        end else begin
          if (have) begin
            for (int j = 0; j < N; j++) if (j == o) line_out[j] = pend;
            o = o + 1;
          end
          pend = line_in[k];
          have = 1'b1;
        end
      end
    end
    if (have) for (int j = 0; j < N; j++) if (j == o) line_out[j] = pend;
    for (int k = 0; k < N; k++) if (line_out[k] != line_in[k]) line_chg = 1'b1;
  end

  assign score_sum = GW'(score) + line_gain;
  assign score_nx  = (line_sat || score_sum > GW'(SCORE_MAX)) ? SCORE_MAX : score_sum[SCORE_W-1:0];

  // Stuck: no empty cell and no equal, mergeable neighbour pair anywhere.
  always_comb begin
    board_stuck = 1'b1;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        if (cells[IDX_W'(r * N + c)] == '0) board_stuck = 1'b0;
        if (c < N - 1 && cells[IDX_W'(r * N + c)] == cells[IDX_W'(r * N + c + 1)] &&
            cells[IDX_W'(r * N + c)] != EXP_MAX) board_stuck = 1'b0;
        if (r < N - 1 && cells[IDX_W'(r * N + c)] == cells[IDX_W'((r + 1) * N + c)] &&
            cells[IDX_W'(r * N + c)] != EXP_MAX) board_stuck = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= INIT;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    key_ready = (state == WAIT) & ~ld_en;
    busy      = (state == INIT) | (state == SPAWN) | (state == MOVE) | (state == CHECK);
    game_over = (state == OVER);
    case (state)
      INIT:  state_nx = SPAWN;
      SPAWN: begin
        if (spawn_hit) begin
          if (spawn_left == 2'd1) state_nx = CHECK;
        end else if (scan_last) begin
          state_nx = CHECK;
        end
      end
      WAIT: begin
        if (ld_en)          state_nx = CHECK;
        else if (key_valid) state_nx = MOVE;
      end
      MOVE:  if (line_last) state_nx = (moved | line_chg) ? SPAWN : WAIT;
      CHECK: state_nx = board_stuck ? OVER : WAIT;
      OVER:  state_nx = OVER;
      default: state_nx = INIT;
    endcase
    if (new_game) state_nx = INIT;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NC; i++) cells[i] <= '0;
      score      <= '0;
      win        <= 1'b0;
      move_done  <= 1'b0;
      rd_exp     <= '0;
      spawn_idx  <= '0;
      scan_cnt   <= '0;
      spawn_left <= '0;
      line_cnt   <= '0;
      move_dir   <= '0;
      moved      <= 1'b0;
      key_pend   <= 1'b0;
    end else begin
      move_done <= 1'b0;
      rd_exp    <= (int'(rd_addr) < NC) ? cells[rd_addr] : '0;
      if (!new_game) begin
        case (state)
          INIT: begin
            for (int i = 0; i < NC; i++) cells[i] <= '0;
            score      <= '0;
            win        <= 1'b0;
            key_pend   <= 1'b0;
            spawn_left <= 2'd2;
            spawn_idx  <= spawn_start;
            scan_cnt   <= '0;
          end
          SPAWN: begin
            if (spawn_hit) begin
              cells[spawn_idx] <= spawn_val;
              spawn_left       <= spawn_left - 1'b1;
              spawn_idx        <= spawn_start;
              scan_cnt         <= '0;
            end else begin
              spawn_idx <= spawn_next;
              scan_cnt  <= scan_cnt + 1'b1;
            end
          end
          WAIT: begin
            if (ld_en) begin
              if (int'(ld_addr) < NC) cells[ld_addr] <= ld_exp;
            end else if (key_valid) begin
              move_dir <= key_dir;
              line_cnt <= '0;
              moved    <= 1'b0;
              key_pend <= 1'b1;
            end
          end
          MOVE: begin
            for (int k = 0; k < N; k++) cells[cell_at(move_dir, line_cnt, k)] <= line_out[k];
            score    <= score_nx;
            win      <= win | line_win;
            moved    <= moved | line_chg;
            line_cnt <= line_cnt + 1'b1;
            if (line_last && (moved || line_chg)) begin
              spawn_left <= 2'd1;
              spawn_idx  <= spawn_start;
              scan_cnt   <= '0;
            end
          end
          default: ;
        endcase
      end
      // First cycle back in WAIT after a key was taken.
      if (state_nx == WAIT && state != WAIT && key_pend) begin
        move_done <= 1'b1;
        key_pend  <= 1'b0;
      end
    end
  end

endmodule
